// File: rtl/redux_pkg.sv
// Shared sizing helpers for the pipelined M-operand carry-save adder.
// redux_levels(M)  : number of registered 3:2 levels needed to reach 2 terms
// redux_width(W,M) : result width that holds the exact sum of M W-bit operands
// redux_terms(M,k) : term count left after k levels
package redux_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int redux_width(input int w, input int m);
    return w + clog2(m);
  endfunction

  function automatic int redux_terms(input int m, input int k);
    int n;
    n = m;
    for (int i = 0; i < k; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int redux_levels(input int m);
    int n;
    int l;
    n = m;
    l = 0;
    for (int i = 0; i < 64; i++)
      if (n > 2) begin
        n = 2 * (n / 3) + n % 3;
        l++;
      end
    return l;
  endfunction

endpackage

// File: rtl/redux_stage.sv
// One registered reduction level plus the 3:2 cell it is built from.
// redux_3     : a,b,c -> s (sum word), cy (carry word shifted left 1, truncated)
// redux_stage : clk, rst_n (sync, active low), en (advance), d_vld/d (N terms in),
//               q_vld/q (redux_terms(N,1) terms out). Leftover N%3 terms pass
//               straight to the register.
module redux_3 #(
  parameter int OW = 11
) (
  input  logic [OW-1:0] a,
  input  logic [OW-1:0] b,
  input  logic [OW-1:0] c,
  output logic [OW-1:0] s,
  output logic [OW-1:0] cy
);
  assign s  = a ^ b ^ c;
  // Carry weight is one bit up; the dropped MSB is harmless since all math is mod 2^OW.
  assign cy = ((a & b) | (a & c) | (b & c)) << 1;
endmodule

module redux_stage
  import redux_pkg::*;
#(
  parameter  int OW = 11,
  parameter  int N  = 8,
  localparam int NO = redux_terms(N, 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            d_vld,
  input  logic [N*OW-1:0] d,
  output logic            q_vld,
  output logic [NO*OW-1:0] q
);
  localparam int NC = N / 3;
  localparam int NR = N % 3;

  logic [NO-1:0][OW-1:0] nxt;

  for (genvar i = 0; i < NC; i++) begin : g_csa
    redux_3 #(.OW(OW)) u_csa (
      .a (d[(3*i)*OW +: OW]),
      .b (d[(3*i+1)*OW +: OW]),
      .c (d[(3*i+2)*OW +: OW]),
      .s (nxt[2*i]),
      .cy(nxt[2*i+1])
    );
  end

  for (genvar j = 0; j < NR; j++) begin : g_pass
    assign nxt[2*NC+j] = d[(3*NC+j)*OW +: OW];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_vld <= 1'b0;
      q     <= '0;
    end else if (en) begin
      q_vld <= d_vld;
      q     <= nxt;
    end
  end
endmodule

// File: rtl/redux_pipe.sv
// Pipelined, flow-controlled M-operand adder (carry-save tree, one register per level).
// clock, reset_n (sync, active low)
// in_valid/in_ready/x : operand set, x[i] = x[i*W +: W]
// out_valid/out_ready/q : result, q[j] = q[j*OW +: OW]
//   FINAL=1: q[0] = sum, q[1] = 0;  FINAL=0: q[0]+q[1] = sum mod 2^OW
// A single global stall (out_valid & ~out_ready) freezes every stage.
module redux_pipe
  import redux_pkg::*;
#(
  parameter  int W      = 8,
  parameter  int M      = 8,
  parameter  int SIGNED = 0,
  parameter  int FINAL  = 1,
  localparam int OW     = redux_width(W, M)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W*M-1:0]  x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*OW-1:0] q
);
  localparam int L   = redux_levels(M);
  localparam int LAT = L + ((FINAL != 0) ? 1 : 0);

  logic                  stall;
  logic [LAT:0]          vld_pipe;
  logic [M-1:0][OW-1:0]  x_ext;
  logic [2*OW-1:0]       cs;

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_pipe[LAT];
  // No stall means the set is taken, so the raw in_valid can enter the pipe.
  assign vld_pipe[0] = in_valid;

  for (genvar i = 0; i < M; i++) begin : g_ext
    assign x_ext[i] = {{(OW-W){(SIGNED != 0) ? x[i*W+W-1] : 1'b0}}, x[i*W +: W]};
  end

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int NI = redux_terms(M, k);
    localparam int NO = redux_terms(M, k + 1);
    logic [NI*OW-1:0] d_w;
    logic [NO*OW-1:0] q_w;
    if (k == 0) begin : g_first
      assign d_w = x_ext;
    end else begin : g_next
      assign d_w = g_lvl[k-1].q_w;
    end
    redux_stage #(.OW(OW), .N(NI)) u_stage (
      .clk  (clock),
      .rst_n(reset_n),
      .en   (~stall),
      .d_vld(vld_pipe[k]),
      .d    (d_w),
      .q_vld(vld_pipe[k+1]),
      .q    (q_w)
    );
  end

  assign cs = g_lvl[L-1].q_w;

  if (FINAL != 0) begin : g_cpa
    logic [OW-1:0] sum_r;
    logic          vld_r;
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        sum_r <= '0;
        vld_r <= 1'b0;
      end else if (!stall) begin
        sum_r <= cs[OW-1:0] + cs[2*OW-1:OW];
        vld_r <= vld_pipe[L];
      end
    end
    assign vld_pipe[LAT] = vld_r;
    assign q = {{OW{1'b0}}, sum_r};
  end else begin : g_cs
    assign q = cs;
  end
endmodule

// File: tb/tb_redux_pipe.sv
module tb_redux_pipe;
  typedef struct {
    logic [31:0] v;
    int          c;
  } ent_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // a: W8 M8 unsigned FINAL1 | b: W8 M8 signed FINAL1 | c: W8 M3 FINAL0 | d: W8 M9 FINAL0
  logic        a_iv, a_ir, a_ov, a_or; logic [63:0] a_x; logic [21:0] a_q; logic [31:0] a_ev;
  logic        b_iv, b_ir, b_ov, b_or; logic [63:0] b_x; logic [21:0] b_q; logic [31:0] b_ev;
  logic        c_iv, c_ir, c_ov, c_or; logic [23:0] c_x; logic [19:0] c_q; logic [31:0] c_ev;
  logic        d_iv, d_ir, d_ov, d_or; logic [71:0] d_x; logic [23:0] d_q; logic [31:0] d_ev;

  redux_pipe #(.W(8), .M(8), .SIGNED(0), .FINAL(1)) u_a (.clock(clock), .reset_n(reset_n),
    .in_valid(a_iv), .in_ready(a_ir), .x(a_x), .out_valid(a_ov), .out_ready(a_or), .q(a_q));
  redux_pipe #(.W(8), .M(8), .SIGNED(1), .FINAL(1)) u_b (.clock(clock), .reset_n(reset_n),
    .in_valid(b_iv), .in_ready(b_ir), .x(b_x), .out_valid(b_ov), .out_ready(b_or), .q(b_q));
  redux_pipe #(.W(8), .M(3), .SIGNED(0), .FINAL(0)) u_c (.clock(clock), .reset_n(reset_n),
    .in_valid(c_iv), .in_ready(c_ir), .x(c_x), .out_valid(c_ov), .out_ready(c_or), .q(c_q));
  redux_pipe #(.W(8), .M(9), .SIGNED(0), .FINAL(0)) u_d (.clock(clock), .reset_n(reset_n),
    .in_valid(d_iv), .in_ready(d_ir), .x(d_x), .out_valid(d_ov), .out_ready(d_or), .q(d_q));

  ent_t qa[$], qb[$], qc[$], qd[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  bit   lat_chk = 0, rnd_or = 0;
  logic a_pst = 1'b0;
  logic [21:0] a_pq = '0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void spurious(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: out_valid with nothing expected (cycle %0d)", nm, cyc);
  endfunction

  function automatic logic [31:0] usum(input logic [71:0] xv, input int m);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < m; i++) s += {24'd0, xv[i*8 +: 8]};
    return s;
  endfunction

  function automatic logic rdy(input int d);
    case (d)
      0: return a_ir;
      1: return b_ir;
      2: return c_ir;
      default: return d_ir;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return qa.size();
      1: return qb.size();
      2: return qc.size();
      default: return qd.size();
    endcase
  endfunction

  task automatic monitor();
    ent_t e;
    logic [9:0]  sc;
    logic [11:0] sd;
    logic        rdy_exp;
    forever begin
      @(negedge clock);
      cyc++;
      if (a_pst) begin
        chk("a_hold_q", a_q, a_pq);
        chk("a_hold_ov", a_ov, 1);
      end
      if (reset_n) begin
        rdy_exp = !(a_ov && !a_or);
        chk("a_in_ready", a_ir, rdy_exp);
        if (a_ov && a_or) begin
          if (qa.size() == 0) spurious("a_spurious");
          else begin
            e = qa.pop_front();
            chk("a_q", a_q, {11'd0, e.v[10:0]});
            if (lat_chk) chk("a_lat", cyc - e.c, 5);
          end
        end
        if (b_ov && b_or) begin
          if (qb.size() == 0) spurious("b_spurious");
          else begin
            e = qb.pop_front();
            chk("b_q", b_q, {11'd0, e.v[10:0]});
            if (lat_chk) chk("b_lat", cyc - e.c, 5);
          end
        end
        if (c_ov && c_or) begin
          if (qc.size() == 0) spurious("c_spurious");
          else begin
            e = qc.pop_front();
            sc = c_q[9:0] + c_q[19:10];
            chk("c_sum", sc, e.v[9:0]);
            if (lat_chk) chk("c_lat", cyc - e.c, 1);
          end
        end
        if (d_ov && d_or) begin
          if (qd.size() == 0) spurious("d_spurious");
          else begin
            e = qd.pop_front();
            sd = d_q[11:0] + d_q[23:12];
            chk("d_sum", sd, e.v[11:0]);
            if (lat_chk) chk("d_lat", cyc - e.c, 4);
          end
        end
        if (a_iv && a_ir) qa.push_back('{a_ev, cyc});
        if (b_iv && b_ir) qb.push_back('{b_ev, cyc});
        if (c_iv && c_ir) qc.push_back('{c_ev, cyc});
        if (d_iv && d_ir) qd.push_back('{d_ev, cyc});
      end else begin
        // the coming edge is a reset: everything in flight is discarded
        qa.delete(); qb.delete(); qc.delete(); qd.delete();
      end
      a_pst = reset_n && a_ov && !a_or;
      a_pq  = a_q;
    end
  endtask

  task automatic or_driver();
    forever begin
      @(posedge clock);
      #1;
      a_or = rnd_or ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send(input int d, input logic [71:0] xv, input logic [31:0] ev);
    int n;
    case (d)
      0: begin a_iv = 1; a_x = xv[63:0]; a_ev = ev; end
      1: begin b_iv = 1; b_x = xv[63:0]; b_ev = ev; end
      2: begin c_iv = 1; c_x = xv[23:0]; c_ev = ev; end
      default: begin d_iv = 1; d_x = xv; d_ev = ev; end
    endcase
    n = 0;
    @(negedge clock);
    while (!rdy(d) && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (n >= 200) chk("send_timeout", n, 0);
    @(posedge clock);
    #1;
    a_iv = 0; b_iv = 0; c_iv = 0; d_iv = 0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("drain_left", qsize(d), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [71:0] xv;
    reset_n = 0;
    a_iv = 0; b_iv = 0; c_iv = 0; d_iv = 0;
    a_x = '0; b_x = '0; c_x = '0; d_x = '0;
    a_ev = 0; b_ev = 0; c_ev = 0; d_ev = 0;
    a_or = 1; b_or = 1; c_or = 1; d_or = 1;
    fork
      monitor();
      or_driver();
      begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    @(negedge clock);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_in_ready", a_ir, 1);
    chk("rst_q", a_q, 0);
    chk("rst_q_b", b_q, 0);
    chk("rst_q_c", c_q, 0);
    chk("rst_q_d", d_q, 0);
    @(posedge clock);
    #1;

    // unsigned directed, latency 5
    lat_chk = 1;
    send(0, {8{8'hFF}}, 32'd2040);
    drain(0);
    send(0, 72'd0, 32'd0);
    send(0, 72'h0807060504030201, 32'd36);
    drain(0);

    // signed directed
    send(1, {8{8'h80}}, 32'h400);
    send(1, 72'hFC04FD03FE02FF01, 32'd0);
    send(1, {8{8'h7F}}, 32'd1016);
    send(1, {8{8'hFF}}, 32'h7F8);
    drain(1);

    // back-to-back random, full rate
    for (int i = 0; i < 100; i++) begin
      xv = {8'd0, $urandom, $urandom};
      send(0, xv, usum(xv, 8));
    end
    drain(0);

    // random valid/ready
    lat_chk = 0;
    rnd_or = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock);
        #1;
      end
      xv = {8'd0, $urandom, $urandom};
      send(0, xv, usum(xv, 8));
    end
    drain(0);
    rnd_or = 0;
    repeat (2) @(posedge clock);
    #1;

    // carry-save output, M=3 and M=9
    lat_chk = 1;
    send(2, 72'hFFFFFF, 32'd765);
    send(2, 72'h030201, 32'd6);
    send(2, 72'h80007F, 32'd255);
    drain(2);
    send(3, {9{8'hFF}}, 32'd2295);
    send(3, 72'h090807060504030201, 32'd45);
    for (int i = 0; i < 10; i++) begin
      xv = {$urandom_range(0, 255), $urandom, $urandom};
      send(3, xv, usum(xv, 9));
    end
    drain(3);

    // reset with sets in flight
    lat_chk = 0;
    d_iv = 1; d_x = {9{8'h11}}; d_ev = 32'd153;
    repeat (3) @(posedge clock);
    #1 d_iv = 0; reset_n = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    repeat (8) begin
      @(negedge clock);
      chk("d_post_rst_ov", d_ov, 0);
    end
    @(posedge clock);
    #1;
    lat_chk = 1;
    send(3, {9{8'h01}}, 32'd9);
    drain(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
